// File: rtl/pipe_pkg.sv
// pipe_pkg: WISC-SP16 decode types, opcodes and the control decoder shared by pipe_decode.
package pipe_pkg;
  typedef struct packed {
    logic [4:0] aluop;
    logic [1:0] func;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       jumpreg;
    logic       set;
    logic       btr;
    logic       inv_a;
    logic       inv_b;
    logic       cin;
    logic       memwrite;
    logic       memread;
    logic       memtoreg;
    logic       halt;
    logic       excp;
  } ctrl_t;
  typedef enum logic [2:0] {IMM_NONE, IMM_I5Z, IMM_I5S, IMM_I8Z, IMM_I8S, IMM_J11} imm_mode_e;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RS, DST_LINK} dst_e;
  typedef struct packed {
    ctrl_t     ctrl;
    imm_mode_e imm;
    dst_e      dst;
    logic      wen;
    logic      use_rs;
    logic      use_rt;
    logic      illegal;
  } dec_t;
  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_SIIC  = 5'b00010;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_SHF   = 5'b11010;
  localparam logic [4:0] OP_ALU   = 5'b11011;
  function automatic dec_t decode_ctrl(input logic [4:0] op, input logic [1:0] func);
    dec_t d;
    d = '0;
    d.ctrl.aluop = op;
    d.ctrl.func = func;
    case (op) inside
      OP_HALT: d.ctrl.halt = 1'b1;
      OP_NOP: ;
      OP_SIIC: d.ctrl.excp = 1'b1;
      OP_J, OP_JAL: begin
        d.ctrl.jump = 1'b1;
        d.imm = IMM_J11;
        d.wen = op[1];
        d.dst = DST_LINK;
      end
      OP_JR, OP_JALR: begin
        d.ctrl.jump = 1'b1;
        d.ctrl.jumpreg = 1'b1;
        d.imm = IMM_I8S;
        d.use_rs = 1'b1;
        d.wen = op[1];
        d.dst = DST_LINK;
      end
      OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI, [5'b10100:5'b10111]: begin
        d.ctrl.alusrc = 1'b1;
        d.ctrl.inv_a = op == OP_SUBI;
        d.ctrl.cin = op == OP_SUBI;
        d.ctrl.inv_b = op == OP_ANDNI;
        d.imm = (op == OP_ADDI || op == OP_SUBI) ? IMM_I5S : IMM_I5Z;
        d.use_rs = 1'b1;
        d.wen = 1'b1;
      end
      [5'b01100:5'b01111]: begin
        d.ctrl.branch = 1'b1;
        d.imm = IMM_I8S;
        d.use_rs = 1'b1;
      end
      OP_ST, OP_LD, OP_STU: begin
        d.ctrl.alusrc = 1'b1;
        d.ctrl.memread = op == OP_LD;
        d.ctrl.memtoreg = op == OP_LD;
        d.ctrl.memwrite = op != OP_LD;
        d.imm = IMM_I5S;
        d.use_rs = 1'b1;
        d.use_rt = op != OP_LD;
        d.wen = op != OP_ST;
        d.dst = op == OP_STU ? DST_RS : DST_RT;
      end
      OP_LBI, OP_SLBI: begin
        d.ctrl.alusrc = 1'b1;
        d.imm = op == OP_LBI ? IMM_I8S : IMM_I8Z;
        d.use_rs = op == OP_SLBI;
        d.wen = 1'b1;
        d.dst = DST_RS;
      end
      OP_BTR: begin
        d.ctrl.btr = 1'b1;
        d.use_rs = 1'b1;
        d.wen = 1'b1;
        d.dst = DST_RD;
      end
      OP_SHF, OP_ALU, [5'b11100:5'b11110]: begin
        d.ctrl.set = op[4:2] == 3'b111;
        d.ctrl.inv_a = op == OP_ALU && func == 2'b01;
        d.ctrl.inv_b = op[4:2] == 3'b111 || (op == OP_ALU && func == 2'b11);
        d.ctrl.cin = op[4:2] == 3'b111 || (op == OP_ALU && func == 2'b01);
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.wen = 1'b1;
        d.dst = DST_RD;
      end
      default: begin
        d = '0;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction
endpackage

// File: rtl/rf_bypass.sv
// rf_bypass: 8-entry register file, combinational reads; PIPE_DECODE_BYPASS_EN forwards same-cycle writes.
module rf_bypass #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [2:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [2:0]        ra1_i,
  input  logic [2:0]        ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);
  logic [7:0][DATA_W-1:0] regs_q;
  always_ff @(posedge clk)
    if (!rst_ni) regs_q <= '0;
    else if (we_i) regs_q[wa_i] <= wd_i;
`ifdef PIPE_DECODE_BYPASS_EN
  assign rd1_o = (we_i && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
  assign rd2_o = (we_i && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
`else
  assign rd1_o = regs_q[ra1_i];
  assign rd2_o = regs_q[ra2_i];
`endif
endmodule

// File: rtl/pipe_decode.sv
// pipe_decode: pipelined WISC-SP16 decode with load-use bubbles and a registered ID/EX stage (PIPE_DECODE_BYPASS_EN in rf_bypass).
module pipe_decode import pipe_pkg::*; #(
  parameter int unsigned DATA_W   = 16,
  parameter logic [2:0]  LINK_REG = 3'd7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc2,
  output logic              id_stall,
  input  logic              ex_ready,
  input  logic              ex_flush,
  input  logic              wb_wen,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc2,
  output ctrl_t             ex_ctrl,
  output logic [2:0]        ex_wreg,
  output logic              ex_wen,
  output logic              ex_err
);
  typedef struct packed {
    logic              valid;
    logic              err;
    logic              wen;
    ctrl_t             ctrl;
    logic [2:0]        wreg;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc2;
  } idex_t;
  dec_t dec;
  idex_t idex_d, idex_q;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic [2:0] wreg;
  logic hold, hazard;
  assign dec = decode_ctrl(if_instr[15:11], if_instr[1:0]);
  rf_bypass #(.DATA_W(DATA_W)) u_rf (
    .clk   (clk),
    .rst_ni(rst),
    .we_i  (wb_wen),
    .wa_i  (wb_reg),
    .wd_i  (wb_data),
    .ra1_i (if_instr[10:8]),
    .ra2_i (if_instr[7:5]),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );
  always_comb
    imm = dec.imm == IMM_I5Z ? DATA_W'(if_instr[4:0]) :
          dec.imm == IMM_I5S ? {{(DATA_W-5){if_instr[4]}}, if_instr[4:0]} :
          dec.imm == IMM_I8Z ? DATA_W'(if_instr[7:0]) :
          dec.imm == IMM_I8S ? {{(DATA_W-8){if_instr[7]}}, if_instr[7:0]} :
          dec.imm == IMM_J11 ? {{(DATA_W-11){if_instr[10]}}, if_instr[10:0]} : '0;
  always_comb
    wreg = dec.dst == DST_RT ? if_instr[7:5] :
           dec.dst == DST_RD ? if_instr[4:2] :
           dec.dst == DST_RS ? if_instr[10:8] : LINK_REG;
  assign hold = idex_q.valid & ~ex_ready;
  assign hazard = idex_q.valid & idex_q.ctrl.memread & idex_q.wen & if_valid &
                  ((dec.use_rs & (idex_q.wreg == if_instr[10:8])) |
                   (dec.use_rt & (idex_q.wreg == if_instr[7:5])));
  assign id_stall = hold | hazard;
  // A hold implies valid was set, so the held valid bit need not be read back.
  always_comb begin
    idex_d = hold ? idex_q : {1'b0, dec.illegal, dec.wen, dec.ctrl, wreg, rd1, rd2, imm, if_pc2};
    idex_d.valid = ~ex_flush & (hold | (if_valid & ~hazard));
  end
  always_ff @(posedge clk) idex_q <= rst ? idex_d : '0;
  assign ex_valid = idex_q.valid;
  assign ex_err = idex_q.err;
  assign ex_wen = idex_q.wen;
  assign ex_ctrl = idex_q.ctrl;
  assign ex_wreg = idex_q.wreg;
  assign ex_op1 = idex_q.op1;
  assign ex_op2 = idex_q.op2;
  assign ex_imm = idex_q.imm;
  assign ex_pc2 = idex_q.pc2;
endmodule

// File: tb/tb_pipe_decode.sv
// tb_pipe_decode: directed self-checking bench for pipe_decode.
module tb_pipe_decode;
  import pipe_pkg::*;
  logic clk = 1'b0;
  logic rst, if_valid, ex_ready, ex_flush, wb_wen, id_stall, ex_valid, ex_wen, ex_err;
  logic [15:0] if_instr, if_pc2, wb_data, ex_op1, ex_op2, ex_imm, ex_pc2;
  logic [2:0] wb_reg, ex_wreg;
  ctrl_t ex_ctrl;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pipe_decode dut (
    .clk     (clk),
    .rst     (rst),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc2  (if_pc2),
    .id_stall(id_stall),
    .ex_ready(ex_ready),
    .ex_flush(ex_flush),
    .wb_wen  (wb_wen),
    .wb_reg  (wb_reg),
    .wb_data (wb_data),
    .ex_valid(ex_valid),
    .ex_op1  (ex_op1),
    .ex_op2  (ex_op2),
    .ex_imm  (ex_imm),
    .ex_pc2  (ex_pc2),
    .ex_ctrl (ex_ctrl),
    .ex_wreg (ex_wreg),
    .ex_wen  (ex_wen),
    .ex_err  (ex_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc2 = pc;
  endtask
  task automatic wb(input logic en, input logic [2:0] r, input logic [15:0] d);
    wb_wen = en;
    wb_reg = r;
    wb_data = d;
  endtask
  task automatic chk_zero(input string p);
    chk({p, "_valid"}, ex_valid, 1'b0);
    chk({p, "_err"}, ex_err, 1'b0);
    chk({p, "_wen"}, ex_wen, 1'b0);
    chk({p, "_ctrl"}, ex_ctrl, 21'h0);
    chk({p, "_op1"}, ex_op1, 16'h0);
    chk({p, "_op2"}, ex_op2, 16'h0);
    chk({p, "_imm"}, ex_imm, 16'h0);
    chk({p, "_pc2"}, ex_pc2, 16'h0);
    chk({p, "_wreg"}, ex_wreg, 3'd0);
    chk({p, "_stall"}, id_stall, 1'b0);
  endtask
  initial begin
    rst = 1'b0;
    ex_ready = 1'b1;
    ex_flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    wb(1'b0, 3'd0, 16'h0);
    tick;
    tick;
    chk_zero("rst");
    rst = 1'b1;
    drive(1'b1, 16'h403D, 16'h0002);
    #1 chk("addi_stall", id_stall, 1'b0);
    tick;
    chk("addi_valid", ex_valid, 1'b1);
    chk("addi_imm", ex_imm, 16'hFFFD);
    chk("addi_wreg", ex_wreg, 3'd1);
    chk("addi_wen", ex_wen, 1'b1);
    chk("addi_op1", ex_op1, 16'h0);
    chk("addi_pc2", ex_pc2, 16'h0002);
    chk("addi_alusrc", ex_ctrl.alusrc, 1'b1);
    drive(1'b1, 16'h8840, 16'h0004);
    wb(1'b1, 3'd1, 16'h0055);
    tick;
    wb(1'b0, 3'd0, 16'h0);
    chk("ld_memread", ex_ctrl.memread, 1'b1);
    chk("ld_wreg", ex_wreg, 3'd2);
    drive(1'b1, 16'hDA2C, 16'h0006);
    #1 chk("lu_stall", id_stall, 1'b1);
    tick;
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_stall_clear", id_stall, 1'b0);
    tick;
    chk("add_valid", ex_valid, 1'b1);
    chk("add_wreg", ex_wreg, 3'd3);
    chk("add_op1", ex_op1, 16'h0);
    chk("add_op2", ex_op2, 16'h0055);
    chk("add_memread", ex_ctrl.memread, 1'b0);
    ex_ready = 1'b0;
    drive(1'b1, 16'h4085, 16'h0008);
    wb(1'b1, 3'd1, 16'h9999);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_stall", id_stall, 1'b1);
      tick;
      wb(1'b0, 3'd0, 16'h0);
      chk("bp_valid", ex_valid, 1'b1);
      chk("bp_wreg", ex_wreg, 3'd3);
      chk("bp_op2", ex_op2, 16'h0055);
      chk("bp_pc2", ex_pc2, 16'h0006);
    end
    ex_ready = 1'b1;
    #1 chk("bp_release", id_stall, 1'b0);
    tick;
    chk("adv_wreg", ex_wreg, 3'd4);
    chk("adv_imm", ex_imm, 16'h0005);
    chk("adv_pc2", ex_pc2, 16'h0008);
    drive(1'b1, 16'h8840, 16'h000A);
    tick;
    drive(1'b1, 16'hDA2C, 16'h000C);
    ex_flush = 1'b1;
    #1 chk("fl_stall", id_stall, 1'b1);
    tick;
    ex_flush = 1'b0;
    chk("fl_valid", ex_valid, 1'b0);
    #1 chk("fl_stall_clear", id_stall, 1'b0);
    tick;
    chk("fl_add_valid", ex_valid, 1'b1);
    chk("fl_add_wreg", ex_wreg, 3'd3);
    chk("fl_add_op2", ex_op2, 16'h9999);
    drive(1'b0, 16'h0, 16'h0);
    wb(1'b1, 3'd3, 16'h00AA);
    tick;
    drive(1'b1, 16'hDB14, 16'h000E);
    wb(1'b1, 3'd3, 16'h1234);
    tick;
    wb(1'b0, 3'd0, 16'h0);
`ifdef PIPE_DECODE_BYPASS_EN
    chk("byp_op1", ex_op1, 16'h1234);
`else
    chk("byp_op1", ex_op1, 16'h00AA);
`endif
    tick;
    chk("byp_after", ex_op1, 16'h1234);
    drive(1'b0, 16'h0, 16'h0);
    wb(1'b1, 3'd0, 16'h0777);
    tick;
    wb(1'b0, 3'd0, 16'h0);
    drive(1'b1, 16'h403D, 16'h0010);
    tick;
    chk("r0_op1", ex_op1, 16'h0777);
    drive(1'b1, 16'hC680, 16'h0012);
    tick;
    chk("lbi_imm", ex_imm, 16'hFF80);
    chk("lbi_wreg", ex_wreg, 3'd6);
    drive(1'b1, 16'h9680, 16'h0014);
    tick;
    chk("slbi_imm", ex_imm, 16'h0080);
    drive(1'b1, 16'h37FE, 16'h0016);
    tick;
    chk("jal_wreg", ex_wreg, 3'd7);
    chk("jal_imm", ex_imm, 16'hFFFE);
    chk("jal_wen", ex_wen, 1'b1);
    chk("jal_jump", ex_ctrl.jump, 1'b1);
    drive(1'b1, 16'hF800, 16'h0018);
    tick;
    chk("ill_valid", ex_valid, 1'b1);
    chk("ill_err", ex_err, 1'b1);
    chk("ill_wen", ex_wen, 1'b0);
    chk("ill_ctrl", ex_ctrl, 21'h0);
    chk("ill_imm", ex_imm, 16'h0);
    drive(1'b1, 16'h8840, 16'h001A);
    tick;
    drive(1'b1, 16'hDA2C, 16'h001C);
    #1 chk("mid_stall", id_stall, 1'b1);
    rst = 1'b0;
    tick;
    chk_zero("mid_rst");
    rst = 1'b1;
    drive(1'b1, 16'hDB14, 16'h001E);
    tick;
    chk("post_rst_valid", ex_valid, 1'b1);
    chk("post_rst_op1", ex_op1, 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_decode.md
# pipe_decode

Pipelined, parametrised decode stage for the WISC-SP16 core; it replaces the single-cycle decode path. It accepts one 16-bit instruction per cycle from fetch and reads operands from an internal register file. It detects load-use hazards and inserts bubbles, extends immediates to `DATA_W`, and presents everything to execute through a registered ID/EX boundary with a valid/ready handshake.

## Interface
- `DATA_W`, 16, datapath/operand width (≥16); immediates and register data are this width.
- `LINK_REG`, 7, register written by JAL/JALR.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-low.
- `if_valid` in 1: fetch presents a valid instruction.
- `if_instr` in 16: instruction word.
- `if_pc2` in `DATA_W`: PC+2 of that instruction.
- `id_stall` out 1: combinational; fetch must hold `if_instr`/`if_pc2`.
- `ex_ready` in 1: execute accepts the ID/EX contents this cycle.
- `ex_flush` in 1: squash the ID/EX contents (taken branch or jump).
- `wb_wen` in 1, `wb_reg` in 3, `wb_data` in `DATA_W`: writeback port.
- `ex_valid` out 1: ID/EX contents are valid.
- `ex_op1`, `ex_op2`, `ex_imm`, `ex_pc2` out `DATA_W`: operands, extended immediate and PC+2.
- `ex_ctrl` out `pkg::ctrl_t`: aluop, func, alusrc, branch, jump, jumpreg, set, btr, invA, invB, cin, memwrite, memread, memtoreg, halt, excp.
- `ex_wreg` out 3, `ex_wen` out 1: destination register and register-file write enable.
- `ex_err` out 1: illegal opcode marker, travels with the instruction.

## Operation
- Control decode of `if_instr[15:11]` with `if_instr[1:0]` produces `ctrl_t` and the immediate mode.
- Immediate modes:
  - I5Z: zero-extend `[4:0]`.
  - I5S: sign-extend `[4:0]`.
  - I8Z: zero-extend `[7:0]`.
  - I8S: sign-extend `[7:0]`.
  - J11: sign-extend `[10:0]`.
  - NONE: immediate is 0.
- Unknown opcode: `ex_err`=1, control fields 0, immediate 0, no write.
- Destination register selection:
  - I-format: `[7:5]`.
  - R-format: `[4:2]`.
  - JAL/JALR: `LINK_REG`.
- Read ports: rs=`[10:8]` and rt=`[7:5]`. Each carries a "used" flag from decode.
- Load-use hazard: `ex_valid & ex_ctrl.memread & ex_wen & ex_wreg`==(used rs or rt) & `if_valid`.
  - Response: `id_stall`=1 and the ID/EX register loads a bubble (`ex_valid`=0); the stalled instruction re-decodes next cycle.
- Backpressure: `ex_valid & !ex_ready` → `id_stall`=1 and the ID/EX register holds all fields.
- Advance: when no stall, ID/EX loads `if_valid` and the decoded fields.
- Flush: `ex_flush`=1 → `ex_valid`=0 next cycle, regardless of stall or backpressure.
  - `id_stall` is not asserted by the flush itself.
- Priority: reset > flush > backpressure hold > load-use bubble > advance.
- Register file: 8×`DATA_W`. Writes on `wb_wen` at the clock edge; reads are combinational.

## Timing
- Latency: an instruction accepted at edge N appears on `ex_*` after edge N.
- Throughput: 1 instruction per cycle with no hazards.
- `id_stall` is combinational from `if_*`, `ex_*` state and `ex_ready`.
- Reset (`rst`=0 at an edge):
  - `ex_valid`, `ex_err`, `ex_wen`, `ex_ctrl`, `ex_op1`, `ex_op2`, `ex_imm`, `ex_pc2`, `ex_wreg` all return to 0.
  - All registers are cleared to 0.
  - `id_stall`=0 while `ex_valid`=0.
- Reset mid-stall discards the held instruction.
- Write to a register during a backpressure hold: the held `ex_op*` values are not updated. The producer's forwarding covers this case.
- Writes to r0 are stored; r0 is a general register.

## Configuration
- `PIPE_DECODE_BYPASS_EN` defined:
  - A read in the same cycle as a `wb_wen` write to the same register returns `wb_data`.
  - This applies to both ports and to `LINK_REG`.
- Not defined:
  - The same-cycle read returns the pre-write value.
  - The writeback stage is then responsible for the hazard.

## Structure
- Package `pipe_pkg` holds:
  - `ctrl_t` packed struct.
  - Opcode localparams.
  - `imm_mode_e` enum.
  - Function `decode_ctrl(opcode, func)` returning `ctrl_t`, immediate mode, used flags and illegal flag.
- Sub-module `rf_bypass`: 8-entry register file with synchronous active-low reset and the optional bypass.
- The hazard logic, immediate extension and ID/EX register live in `pipe_decode`.

## Test plan
- ADDI r1,r0,-3 with r0=0 → `ex_imm`=16'hFFFD, `ex_wreg`=1, `ex_valid`=1 one cycle later.
- LD r2 then ADD using r2 back-to-back → `id_stall`=1 for exactly 1 cycle, one bubble (`ex_valid`=0), then the ADD with `ex_wreg` correct.
- `ex_ready`=0 for 3 cycles with a valid instruction → `id_stall`=1 and `ex_*` stable for all 3 cycles; advance on the 4th cycle.
- `ex_flush` asserted together with a load-use stall → next `ex_valid`=0 and the stall clears.
- Same-cycle `wb_wen` r3=16'h1234 and a read of r3:
  - With `PIPE_DECODE_BYPASS_EN`: `ex_op1`=16'h1234.
  - Without it: `ex_op1` holds the old r3 value.
- Illegal opcode 5'b11111 → `ex_err`=1, `ex_wen`=0. Then `rst` low mid-stream → every output is 0 on the next edge.
